// File: rtl/hack_mem_arbiter.sv
// Hack data-memory arbiter: shares one synchronous RAM between the CPU data port
// and video scan-out, and decodes the keyboard register and out-of-range CPU accesses.
module hack_mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [14:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    output logic        cpu_ack_o,
    output logic [15:0] cpu_rdata_o,
    input  logic        vid_req_i,
    input  logic        vid_urgent_i,
    input  logic [12:0] vid_addr_i,
    output logic        vid_ack_o,
    output logic [15:0] vid_rdata_o,
    input  logic [15:0] kbd_i,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [14:0] ram_addr_o,
    output logic [15:0] ram_wdata_o,
    input  logic [15:0] ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic        GNT_CPU  = 1'b0;
    localparam logic        GNT_VID  = 1'b1;
    localparam logic [14:0] KBD_ADDR = 15'h6000;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  wait_q, wait_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [14:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] vid_rdata_q, vid_rdata_d;
    logic        vid_wins;

    // Urgent video always wins; otherwise alternate away from the last grant.
    assign vid_wins = vid_req_i & (vid_urgent_i | ~cpu_req_i | (last_q == GNT_CPU));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        wait_d      = wait_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        case (state_q)
            IDLE: begin
                if (vid_wins) begin
                    gnt_d      = GNT_VID;
                    last_d     = GNT_VID;
                    wr_d       = 1'b0;
                    ram_en_d   = 1'b1;
                    ram_addr_d = {2'b10, vid_addr_i};
                    state_d    = ISSUE;
                end else if (cpu_req_i) begin
                    gnt_d  = GNT_CPU;
                    last_d = GNT_CPU;
                    wr_d   = cpu_we_i;
                    if (cpu_addr_i < KBD_ADDR) begin
                        ram_en_d   = 1'b1;
                        ram_we_d   = cpu_we_i;
                        ram_addr_d = cpu_addr_i;
                        state_d    = ISSUE;
                        if (cpu_we_i) begin
                            ram_wdata_d = cpu_wdata_i;
                            cpu_rdata_d = '0;
                        end
                    end else begin
                        cpu_rdata_d = (cpu_addr_i == KBD_ADDR && !cpu_we_i) ? kbd_i : '0;
                        state_d     = DONE;
                    end
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = DONE;
                end else begin
                    wait_d  = 2'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            // Read data becomes valid RD_LAT cycles after the ISSUE edge; capture on the last one.
            WAIT: begin
                if (wait_q == 2'd0) begin
                    if (gnt_q == GNT_VID) vid_rdata_d = ram_rdata_i;
                    else                  cpu_rdata_d = ram_rdata_i;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= GNT_VID;
            gnt_q       <= GNT_CPU;
            wr_q        <= 1'b0;
            wait_q      <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            wait_q      <= wait_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign cpu_ack_o   = (state_q == DONE) && (gnt_q == GNT_CPU);
    assign vid_ack_o   = (state_q == DONE) && (gnt_q == GNT_VID);
    assign cpu_rdata_o = cpu_rdata_q;
    assign vid_rdata_o = vid_rdata_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule
